// File: rtl/soft_rst_gen.sv
// Soft reset request generator: keyed register write or filtered PLL lock loss
// produces a stretched active-low soft_rst pulse followed by a hold-off window.
module soft_rst_gen #(
  parameter logic [15:0] RST_KEY     = 16'hA55A,
  parameter logic [15:0] PULSE_WIDTH = 16'd1000,
  parameter logic [15:0] HOLDOFF     = 16'd4000,
  parameter logic [7:0]  LOCK_FILT   = 8'd16
) (
  input  logic        clk_125m,
  input  logic        rst_125m_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  input  logic        pll_lock,
  input  logic        lock_mon_en,
  output logic        soft_rst,
  output logic        busy,
  output logic [1:0]  rst_cause,
  output logic [7:0]  rst_cnt
);

  // Terminal counts; a zero-length phase still lasts one cycle.
  localparam logic [15:0] PW_LAST = (PULSE_WIDTH == 16'd0) ? 16'd0 : PULSE_WIDTH - 16'd1;
  localparam logic [15:0] HO_LAST = (HOLDOFF == 16'd0) ? 16'd0 : HOLDOFF - 16'd1;

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  lock_sync;
  logic        lock_s;
  logic [7:0]  filt_cnt;
  logic        lock_armed;
  logic        write_trig, lock_trig, trig;
  logic        soft_rst_nxt, busy_nxt;
  logic [1:0]  cause_nxt;
  logic [7:0]  rst_cnt_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign lock_s     = lock_sync[1];
  assign lock_trig  = (filt_cnt == LOCK_FILT) && lock_armed && lock_mon_en;
  assign write_trig = wr_en && (wr_data == RST_KEY) && (state == IDLE);
  assign trig       = (state == IDLE) && (write_trig || lock_trig);

  // Lock synchronizer and loss filter; re-arming needs lock seen high again.
  always_ff @(posedge clk_125m or negedge rst_125m_n) begin
    if (!rst_125m_n) begin
      lock_sync  <= 2'b11;
      filt_cnt   <= 8'd0;
      lock_armed <= 1'b1;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
      if (lock_s) begin
        filt_cnt   <= 8'd0;
        lock_armed <= 1'b1;
      end else begin
        if (filt_cnt != LOCK_FILT) filt_cnt <= filt_cnt + 8'd1;
        if (trig && lock_trig) lock_armed <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    soft_rst_nxt = 1'b1;
    busy_nxt     = 1'b0;
    cause_nxt    = rst_cause;
    rst_cnt_nxt  = rst_cnt;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt    = ASSERT;
          cnt_nxt      = 16'd0;
          soft_rst_nxt = 1'b0;
          busy_nxt     = 1'b1;
          cause_nxt    = {lock_trig, write_trig};
          rst_cnt_nxt  = sat_inc(rst_cnt);
        end
      end
      ASSERT: begin
        busy_nxt = 1'b1;
        if (cnt == PW_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt      = cnt + 16'd1;
          soft_rst_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (cnt == HO_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt  = cnt + 16'd1;
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_125m or negedge rst_125m_n) begin
    if (!rst_125m_n) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      soft_rst  <= 1'b1;
      busy      <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      rst_cause <= 2'b00;
      rst_cnt   <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      soft_rst  <= soft_rst_nxt;
      busy      <= busy_nxt;
      wr_ack    <= write_trig;
      wr_err    <= wr_en && !write_trig;
      rst_cause <= cause_nxt;
      rst_cnt   <= rst_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_soft_rst_gen.sv
// Bench for soft_rst_gen: default-parameter instance checked against a
// timeline model, plus a zero-width/zero-holdoff instance for edge cases.
module tb_soft_rst_gen;
  localparam logic [15:0] KEY = 16'hA55A;
  localparam int PW = 1000;
  localparam int HO = 4000;
  localparam int LF = 16;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic rst0_n, wr_en0, wr_ack0, wr_err0, pll_lock0, lock_mon_en0, soft_rst0, busy0;
  logic [15:0] wr_data0;
  logic [1:0]  rst_cause0;
  logic [7:0]  rst_cnt0;
  logic rst1_n, wr_en1, wr_ack1, wr_err1, pll_lock1, lock_mon_en1, soft_rst1, busy1;
  logic [15:0] wr_data1;
  logic [1:0]  rst_cause1;
  logic [7:0]  rst_cnt1;

  soft_rst_gen dut0 (
    .clk_125m(clk), .rst_125m_n(rst0_n), .wr_en(wr_en0), .wr_data(wr_data0),
    .wr_ack(wr_ack0), .wr_err(wr_err0), .pll_lock(pll_lock0), .lock_mon_en(lock_mon_en0),
    .soft_rst(soft_rst0), .busy(busy0), .rst_cause(rst_cause0), .rst_cnt(rst_cnt0)
  );

  soft_rst_gen #(.PULSE_WIDTH(16'd0), .HOLDOFF(16'd0)) dut1 (
    .clk_125m(clk), .rst_125m_n(rst1_n), .wr_en(wr_en1), .wr_data(wr_data1),
    .wr_ack(wr_ack1), .wr_err(wr_err1), .pll_lock(pll_lock1), .lock_mon_en(lock_mon_en1),
    .soft_rst(soft_rst1), .busy(busy1), .rst_cause(rst_cause1), .rst_cnt(rst_cnt1)
  );

  int errors = 0;
  int checks = 0;

  // Timeline model of dut0: a pulse is fully described by its trigger cycle.
  int cyc, trig_at, run, m_cnt;
  bit s0, s1, armed, m_ack, m_err;
  bit [1:0] m_cause;
  int mism, mism_cyc;
  logic [13:0] mism_got, mism_exp;

  function automatic logic [13:0] model_vec();
    logic lo, bz;
    lo = (cyc >= trig_at + 1) && (cyc <= trig_at + PW);
    bz = (cyc >= trig_at + 1) && (cyc <= trig_at + PW + HO);
    return {~lo, bz, m_ack, m_err, m_cause, m_cnt[7:0]};
  endfunction

  task automatic model_reset();
    trig_at = -100000; run = 0; m_cnt = 0;
    s0 = 1'b1; s1 = 1'b1; armed = 1'b1; m_ack = 1'b0; m_err = 1'b0; m_cause = 2'b00;
  endtask

  task automatic model_step();
    bit idle, ltrig, wtrig;
    idle  = cyc > trig_at + PW + HO;
    ltrig = (run >= LF) && armed && lock_mon_en0;
    wtrig = idle && wr_en0 && (wr_data0 == KEY);
    m_ack = wtrig;
    m_err = wr_en0 && !wtrig;
    if (idle && (wtrig || ltrig)) begin
      trig_at = cyc;
      m_cause = {ltrig, wtrig};
      if (m_cnt < 255) m_cnt++;
      if (ltrig) armed = 1'b0;
    end
    if (s1) begin
      run = 0;
      armed = 1'b1;
    end else if (run < LF) begin
      run++;
    end
    s1 = s0;
    s0 = pll_lock0;
    cyc++;
  endtask

  task automatic tick();
    logic [13:0] got, exp;
    model_step();
    @(posedge clk);
    #1;
    got = {soft_rst0, busy0, wr_ack0, wr_err0, rst_cause0, rst_cnt0};
    exp = model_vec();
    if (got !== exp) begin
      if (mism == 0) begin
        mism_cyc = cyc; mism_got = got; mism_exp = exp;
      end
      mism++;
    end
  endtask

  task automatic run_pulse(input int wr_at, output int lows, output int busys,
                           output bit saw_ack, output bit saw_err);
    lows = 0; busys = 0; saw_ack = 1'b0; saw_err = 1'b0;
    for (int i = 0; i < 12000 && busy0 === 1'b1; i++) begin
      if (soft_rst0 === 1'b0) lows++;
      busys++;
      wr_en0 = (i == wr_at);
      wr_data0 = KEY;
      tick();
      if (wr_ack0 === 1'b1) saw_ack = 1'b1;
      if (wr_err0 === 1'b1) saw_err = 1'b1;
      wr_en0 = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({soft_rst0, busy0, wr_ack0, wr_err0, rst_cause0, rst_cnt0} !== 14'b1_0_0_0_00_00000000) begin
      errors++;
      $display("FAIL reset0: got sr=%b busy=%b ack=%b err=%b cause=%b cnt=%0d, want 1 0 0 0 00 0",
               soft_rst0, busy0, wr_ack0, wr_err0, rst_cause0, rst_cnt0);
    end
    checks++;
    if ({soft_rst1, busy1, wr_ack1, wr_err1, rst_cause1, rst_cnt1} !== 14'b1_0_0_0_00_00000000) begin
      errors++;
      $display("FAIL reset1: got sr=%b busy=%b cnt=%0d, want 1 0 0", soft_rst1, busy1, rst_cnt1);
    end
  endtask

  task automatic test_key_write();
    int lows, busys;
    bit a, e;
    mism = 0;
    wr_en0 = 1'b1; wr_data0 = KEY;
    tick();
    wr_en0 = 1'b0;
    checks++;
    if (wr_ack0 !== 1'b1 || wr_err0 !== 1'b0 || soft_rst0 !== 1'b0) begin
      errors++;
      $display("FAIL key_ack: got ack=%b err=%b sr=%b, want 1 0 0", wr_ack0, wr_err0, soft_rst0);
    end
    run_pulse(-1, lows, busys, a, e);
    checks++;
    if (lows != PW || busys != PW + HO) begin
      errors++;
      $display("FAIL key_width: got low=%0d busy=%0d, want %0d %0d", lows, busys, PW, PW + HO);
    end
    checks++;
    if (rst_cause0 !== 2'b01 || rst_cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL key_status: got cause=%b cnt=%0d, want 01 1", rst_cause0, rst_cnt0);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL key_trace: %0d cycles differ, first cyc %0d got %h want %h", mism, mism_cyc, mism_got, mism_exp);
    end
  endtask

  task automatic test_bad_key();
    int lows, busys;
    bit a, e;
    mism = 0;
    wr_en0 = 1'b1; wr_data0 = 16'h1234;
    tick();
    wr_en0 = 1'b0;
    checks++;
    if (wr_err0 !== 1'b1 || wr_ack0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_key_err: got err=%b ack=%b, want 1 0", wr_err0, wr_ack0);
    end
    repeat (5) tick();
    checks++;
    if (soft_rst0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_key_nopulse: got sr=%b busy=%b, want 1 0", soft_rst0, busy0);
    end
    wr_en0 = 1'b1; wr_data0 = KEY;
    tick();
    wr_en0 = 1'b0;
    run_pulse(100, lows, busys, a, e);
    checks++;
    if (e !== 1'b1 || a !== 1'b0) begin
      errors++;
      $display("FAIL busy_write: got err=%b ack=%b, want 1 0", e, a);
    end
    checks++;
    if (lows != PW || busys != PW + HO || rst_cnt0 !== 8'd2) begin
      errors++;
      $display("FAIL busy_write_width: got low=%0d busy=%0d cnt=%0d, want %0d %0d 2",
               lows, busys, rst_cnt0, PW, PW + HO);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL bad_key_trace: %0d cycles differ, first cyc %0d got %h want %h", mism, mism_cyc, mism_got, mism_exp);
    end
  endtask

  task automatic test_lock_loss();
    int lows, busys, n;
    bit a, e, stayed;
    mism = 0;
    lock_mon_en0 = 1'b1;
    stayed = 1'b1;
    pll_lock0 = 1'b0;
    repeat (10) begin tick(); if (soft_rst0 !== 1'b1) stayed = 1'b0; end
    pll_lock0 = 1'b1;
    repeat (40) begin tick(); if (soft_rst0 !== 1'b1) stayed = 1'b0; end
    checks++;
    if (!stayed) begin
      errors++;
      $display("FAIL short_loss: got a pulse from a 10-cycle loss, want none");
    end
    pll_lock0 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (soft_rst0 === 1'b1 && n < 100);
    checks++;
    if (n != 2 + LF + 1) begin
      errors++;
      $display("FAIL lock_latency: got %0d cycles, want %0d", n, 2 + LF + 1);
    end
    checks++;
    if (rst_cause0 !== 2'b10 || rst_cnt0 !== 8'd3) begin
      errors++;
      $display("FAIL lock_status: got cause=%b cnt=%0d, want 10 3", rst_cause0, rst_cnt0);
    end
    run_pulse(-1, lows, busys, a, e);
    stayed = 1'b1;
    repeat (300) begin tick(); if (soft_rst0 !== 1'b1) stayed = 1'b0; end
    checks++;
    if (lows != PW || !stayed || rst_cnt0 !== 8'd3) begin
      errors++;
      $display("FAIL lock_once: got low=%0d nopulse=%b cnt=%0d, want %0d 1 3", lows, stayed, rst_cnt0, PW);
    end
    pll_lock0 = 1'b1;
    repeat (5) tick();
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL lock_trace: %0d cycles differ, first cyc %0d got %h want %h", mism, mism_cyc, mism_got, mism_exp);
    end
  endtask

  task automatic test_simultaneous();
    int lows, busys;
    bit a, e;
    mism = 0;
    pll_lock0 = 1'b0;
    repeat (2 + LF) tick();
    wr_en0 = 1'b1; wr_data0 = KEY;
    tick();
    wr_en0 = 1'b0;
    checks++;
    if (wr_ack0 !== 1'b1 || soft_rst0 !== 1'b0 || rst_cause0 !== 2'b11 || rst_cnt0 !== 8'd4) begin
      errors++;
      $display("FAIL both_trig: got ack=%b sr=%b cause=%b cnt=%0d, want 1 0 11 4",
               wr_ack0, soft_rst0, rst_cause0, rst_cnt0);
    end
    run_pulse(-1, lows, busys, a, e);
    checks++;
    if (lows != PW || rst_cnt0 !== 8'd4) begin
      errors++;
      $display("FAIL both_width: got low=%0d cnt=%0d, want %0d 4", lows, rst_cnt0, PW);
    end
    pll_lock0 = 1'b1;
    repeat (5) tick();
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL both_trace: %0d cycles differ, first cyc %0d got %h want %h", mism, mism_cyc, mism_got, mism_exp);
    end
  endtask

  task automatic test_mid_reset();
    mism = 0;
    wr_en0 = 1'b1; wr_data0 = KEY;
    tick();
    wr_en0 = 1'b0;
    repeat (300) tick();
    checks++;
    if (soft_rst0 !== 1'b0 || mism != 0) begin
      errors++;
      $display("FAIL pre_reset: got sr=%b diffs=%0d, want 0 0", soft_rst0, mism);
    end
    #2 rst0_n = 1'b0;
    #1;
    checks++;
    if (soft_rst0 !== 1'b1 || busy0 !== 1'b0 || rst_cnt0 !== 8'd0 || rst_cause0 !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got sr=%b busy=%b cnt=%0d cause=%b, want 1 0 0 00",
               soft_rst0, busy0, rst_cnt0, rst_cause0);
    end
    model_reset();
    #1 rst0_n = 1'b1;
  endtask

  task automatic test_random();
    int low_left;
    mism = 0;
    low_left = 0;
    for (int i = 0; i < 25000; i++) begin
      wr_en0 = ($urandom_range(0, 299) == 0);
      wr_data0 = ($urandom_range(0, 1) == 1) ? KEY : 16'($urandom);
      if (low_left > 0) begin
        pll_lock0 = 1'b0;
        low_left--;
      end else begin
        pll_lock0 = 1'b1;
        if ($urandom_range(0, 499) == 0) low_left = $urandom_range(1, 60);
      end
      if ($urandom_range(0, 2999) == 0) lock_mon_en0 = ~lock_mon_en0;
      tick();
    end
    wr_en0 = 1'b0;
    pll_lock0 = 1'b1;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL random_trace: %0d cycles differ, first cyc %0d got %h want %h", mism, mism_cyc, mism_got, mism_exp);
    end
    checks++;
    if (rst_cnt0 !== 8'(m_cnt)) begin
      errors++;
      $display("FAIL random_count: got %0d, want %0d", rst_cnt0, m_cnt);
    end
  endtask

  task automatic test_min_pulse();
    wr_en1 = 1'b1; wr_data1 = KEY;
    tick();
    wr_en1 = 1'b0;
    checks++;
    if (wr_ack1 !== 1'b1 || soft_rst1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL min_assert: got ack=%b sr=%b busy=%b, want 1 0 1", wr_ack1, soft_rst1, busy1);
    end
    tick();
    checks++;
    if (soft_rst1 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL min_holdoff: got sr=%b busy=%b, want 1 1", soft_rst1, busy1);
    end
    tick();
    checks++;
    if (soft_rst1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL min_idle: got sr=%b busy=%b, want 1 0", soft_rst1, busy1);
    end
    wr_en1 = 1'b1;
    tick();
    wr_en1 = 1'b0;
    checks++;
    if (wr_ack1 !== 1'b1 || wr_err1 !== 1'b0 || rst_cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL min_rewrite: got ack=%b err=%b cnt=%0d, want 1 0 2", wr_ack1, wr_err1, rst_cnt1);
    end
    tick();
    tick();
  endtask

  task automatic test_saturate();
    int acks;
    acks = 0;
    for (int i = 0; i < 300; i++) begin
      wr_en1 = 1'b1; wr_data1 = KEY;
      tick();
      wr_en1 = 1'b0;
      if (wr_ack1 === 1'b1) acks++;
      tick();
      tick();
    end
    checks++;
    if (acks != 300 || rst_cnt1 !== 8'd255) begin
      errors++;
      $display("FAIL saturate: got acks=%0d cnt=%0d, want 300 255", acks, rst_cnt1);
    end
  endtask

  initial begin
    rst0_n = 1'b0; wr_en0 = 1'b0; wr_data0 = 16'h0; pll_lock0 = 1'b1; lock_mon_en0 = 1'b0;
    rst1_n = 1'b0; wr_en1 = 1'b0; wr_data1 = 16'h0; pll_lock1 = 1'b1; lock_mon_en1 = 1'b0;
    cyc = 0;
    mism = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    test_key_write();
    test_bad_key();
    test_lock_loss();
    test_simultaneous();
    test_mid_reset();
    test_random();
    test_min_pulse();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soft_rst_gen.md
Name: soft_rst_gen

Overview:
Produces the active-low soft_rst request consumed by the board clock/reset manager. The stretched pulse is triggered by either of two sources:
- a keyed ARM register write;
- a filtered loss of PLL lock.
The block enforces a minimum pulse width and a hold-off period, and reports status to the register map. It must sit on a reset that soft_rst does not drive (hard/power-up domain only), so it survives the reset it requests.

Parameters:
RST_KEY, 16'hA55A, write value that triggers a soft reset
PULSE_WIDTH, 16'd1000, soft_rst low time in clk_125m cycles (8 us); value 0 treated as 1
HOLDOFF, 16'd4000, cycles after release during which new requests are rejected
LOCK_FILT, 8'd16, consecutive synchronized lock-low samples needed to trigger

Ports:
clk_125m  input  1  125 MHz system clock
rst_125m_n  input  1  asynchronous active-low reset, hard/power-up domain only
wr_en  input  1  single-cycle register write strobe
wr_data  input  16  register write data
wr_ack  output  1  1-cycle pulse: write accepted (key matched, IDLE)
wr_err  output  1  1-cycle pulse: write rejected (bad key or not IDLE)
pll_lock  input  1  asynchronous PLL lock indicator
lock_mon_en  input  1  enables lock-loss triggered reset
soft_rst  output  1  active-low soft reset request to CRM
busy  output  1  high in ASSERT and HOLDOFF
rst_cause  output  2  last cause: 01 = register write, 10 = lock loss, 11 = both in same cycle
rst_cnt  output  8  saturating count of soft resets issued

Behaviour:
- Reset (rst_125m_n low, asynchronous):
  - state = IDLE; soft_rst = 1; busy = 0; wr_ack = wr_err = 0; rst_cause = 00; rst_cnt = 0.
  - Lock sync flops = 1; lock filter counter = 0; lock_armed = 1.
- Lock synchronizer: pll_lock passes through a 2-FF synchronizer into lock_s.
- Lock filter:
  - lock_s = 1: clear the filter counter and set lock_armed = 1.
  - lock_s = 0: increment the filter counter, saturating at LOCK_FILT.
  - lock_trig = (counter == LOCK_FILT) & lock_armed & lock_mon_en.
- Write response: wr_ack or wr_err pulses exactly 1 cycle after every wr_en; never both.
- State machine (all outputs registered):
  - IDLE:
    - wr_en & wr_data == RST_KEY gives write_trig; wr_ack next cycle.
    - Any other wr_en gives wr_err.
    - On write_trig or lock_trig: go to ASSERT; clear the 16-bit counter; set rst_cause; rst_cnt++ (saturating at 255); lock_armed = 0 if lock_trig.
  - ASSERT:
    - soft_rst = 0 from the first ASSERT cycle, i.e. the cycle after the trigger cycle.
    - Remains 0 for exactly max(PULSE_WIDTH,1) cycles, then go to HOLDOFF with the counter cleared.
  - HOLDOFF:
    - soft_rst = 1, busy = 1 for HOLDOFF cycles, then IDLE.
    - HOLDOFF = 0 returns to IDLE after 1 cycle.
- Trigger latency: soft_rst falls 1 clock after the trigger cycle.
- Writes outside IDLE: wr_err, no state change, no extension of the pulse.
- Lock loss outside IDLE: ignored. lock_armed is still cleared only by an accepted trigger, so a lock loss persisting through HOLDOFF triggers once on return to IDLE if lock is still low and armed.
- Simultaneous triggers: write_trig and lock_trig in the same IDLE cycle give one pulse, rst_cause = 11, wr_ack, lock_armed = 0, rst_cnt +1.
- Retrigger rule: a persistent lock loss triggers only once; lock must return high (lock_s = 1 for ≥1 cycle) to re-arm.
- Mid-operation reset: rst_125m_n low during ASSERT immediately forces soft_rst = 1 and state IDLE.
- lock_mon_en deasserted mid-count: the filter keeps counting, but lock_trig is suppressed.

Test Plan:
1. Reset release, then wr_en with 16'hA55A → wr_ack at +1; soft_rst low from +1 for exactly 1000 cycles; busy high 5000 cycles total; rst_cause = 01; rst_cnt = 1.
2. wr_en with 16'h1234 in IDLE, then 16'hA55A during ASSERT → wr_err both times; no pulse from the bad key; pulse width unchanged at 1000.
3. lock_mon_en = 1; pll_lock low for 10 cycles, then high → no trigger. Then pll_lock held low → soft_rst falls 2 (sync) + 16 + 1 cycles after the drop; rst_cause = 10; no second pulse after HOLDOFF while lock stays low.
4. Key write in the same cycle lock_trig fires → single 1000-cycle pulse; rst_cause = 11; rst_cnt increments by 1; wr_ack.
5. rst_125m_n asserted 300 cycles into ASSERT → soft_rst = 1, busy = 0, rst_cnt = 0 asynchronously. Then 300 accepted triggers → rst_cnt saturates at 255.
6. PULSE_WIDTH = 0, HOLDOFF = 0 → 1-cycle soft_rst low, 1-cycle HOLDOFF, back to IDLE; next key write accepted.
